// File: rtl/shake_pkg.sv
// Shared types and helpers for the SHAKE output-side (squeeze/dump) logic.
// Holds the dump FSM state encoding and the byte-keep mask builder.
package shake_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BLK = 2'd1,
        DUMP     = 2'd2
    } dump_state_t;

    // Widest keep mask the helper can build (supports W up to 512 bits).
    localparam int unsigned KEEP_MAX = 64;

    // Mask with the lowest n_bytes bits set; callers truncate to their own byte width.
    function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned n_bytes);
        logic [KEEP_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            m[i] = (i < n_bytes);
        end
        return m;
    endfunction

endpackage

// File: rtl/dump_len_counter.sv
// Remaining-byte counter for one squeeze request.
// Flags the final word and produces its byte-accurate keep mask.
module dump_len_counter #(
    parameter int W     = 64,
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [LEN_W-1:0] value,
    input  logic             dec,
    output logic             final_word,
    output logic [W/8-1:0]   keep
);
    import shake_pkg::*;

    localparam int WB = W / 8;
    localparam logic [LEN_W-1:0] WB_L = LEN_W'(WB);

    logic [LEN_W-1:0] r_bytes_rem;
    logic [31:0]      w_tail_bytes;

    assign final_word = (r_bytes_rem <= WB_L);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_bytes_rem <= '0;
        end else if (load) begin
            r_bytes_rem <= value;
        end else if (dec) begin
            // Clamp to zero on the final word so the count never wraps.
            r_bytes_rem <= final_word ? '0 : r_bytes_rem - WB_L;
        end
    end

    // Only meaningful when final_word is set, where the count fits in WB.
    assign w_tail_bytes = 32'(r_bytes_rem);
    assign keep         = final_word ? WB'(keep_mask(w_tail_bytes)) : '1;

endmodule

// File: rtl/squeeze_dump_fsm.sv
// Output-side controller of the SHAKE core: streams the requested byte count from the
// rate buffer onto a ready/valid port, requesting a new permutation per exhausted block.
module squeeze_dump_fsm #(
    parameter int W          = 64,
    parameter int RATE_WORDS = 21,
    parameter int LEN_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] out_len,
    input  logic             flush,
    input  logic             output_buffer_we,
    input  logic             ready_in,
    output logic             valid_out,
    output logic             last_out,
    output logic [W/8-1:0]   keep_out,
    output logic             output_buffer_shift_en,
    output logic             output_buffer_available_wr,
    output logic             squeeze_req,
    output logic             done
);
    import shake_pkg::*;

    localparam int WB    = W / 8;
    localparam int CNT_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_WORDS - 1);

    dump_state_t      r_state;
    dump_state_t      w_next;
    logic [CNT_W-1:0] r_word_cnt;
    logic             r_done;
    logic             w_done_next;
    logic             w_final;
    logic             w_fire;
    logic             w_load;
    logic [WB-1:0]    w_keep;

    assign w_fire = (r_state == DUMP) && ready_in;
    assign w_load = (r_state == IDLE) && start && (out_len != '0);

    dump_len_counter #(
        .W     (W),
        .LEN_W (LEN_W)
    ) u_len (
        .clk        (clk),
        .rst        (rst),
        .clr        (flush),
        .load       (w_load),
        .value      (out_len),
        .dec        (w_fire),
        .final_word (w_final),
        .keep       (w_keep)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_done_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (out_len == '0) w_done_next = 1'b1;
                    else               w_next      = WAIT_BLK;
                end
            end
            WAIT_BLK: begin
                if (output_buffer_we) w_next = DUMP;
            end
            DUMP: begin
                if (ready_in) begin
                    if (w_final) begin
                        w_next      = IDLE;
                        w_done_next = 1'b1;
                    end else if (r_word_cnt == LAST_IDX) begin
                        w_next = WAIT_BLK;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
        // Abort wins over any pending transition and suppresses completion.
        if (flush) begin
            w_next      = IDLE;
            w_done_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_word_cnt <= '0;
        end else if ((r_state == WAIT_BLK) && output_buffer_we) begin
            r_word_cnt <= '0;
        end else if (w_fire) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
    end

    // Outputs decode state directly; reset forces them low even before the first edge.
    always_comb begin
        valid_out                  = 1'b0;
        last_out                   = 1'b0;
        keep_out                   = '0;
        output_buffer_shift_en     = 1'b0;
        output_buffer_available_wr = 1'b0;
        squeeze_req                = 1'b0;
        done                       = r_done && !rst;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    output_buffer_available_wr = 1'b1;
                end
                WAIT_BLK: begin
                    output_buffer_available_wr = 1'b1;
                    squeeze_req                = 1'b1;
                end
                DUMP: begin
                    valid_out              = 1'b1;
                    last_out               = w_final;
                    keep_out               = w_keep;
                    output_buffer_shift_en = ready_in;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_squeeze_dump_fsm.sv
// Randomized bench for squeeze_dump_fsm: a request-level byte/beat model drives the
// expected keep, last, block-load and done behaviour under random backpressure.
module tb_squeeze_dump_fsm;

    localparam int W          = 64;
    localparam int RATE_WORDS = 21;
    localparam int LEN_W      = 32;
    localparam int WB         = W / 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] out_len;
    logic             flush;
    logic             output_buffer_we;
    logic             ready_in;
    logic             valid_out;
    logic             last_out;
    logic [WB-1:0]    keep_out;
    logic             output_buffer_shift_en;
    logic             output_buffer_available_wr;
    logic             squeeze_req;
    logic             done;

    int total = 0;
    int bad   = 0;

    squeeze_dump_fsm #(
        .W          (W),
        .RATE_WORDS (RATE_WORDS),
        .LEN_W      (LEN_W)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .start                      (start),
        .out_len                    (out_len),
        .flush                      (flush),
        .output_buffer_we           (output_buffer_we),
        .ready_in                   (ready_in),
        .valid_out                  (valid_out),
        .last_out                   (last_out),
        .keep_out                   (keep_out),
        .output_buffer_shift_en     (output_buffer_shift_en),
        .output_buffer_available_wr (output_buffer_available_wr),
        .squeeze_req                (squeeze_req),
        .done                       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_keep(input longint len, input int beat);
        longint rem;
        rem = len - longint'(beat) * WB;
        if (rem >= WB) return (64'd1 << WB) - 64'd1;
        return (64'd1 << rem) - 64'd1;
    endfunction

    // One full request: acts as datapath (answers squeeze_req) and as consumer.
    task automatic run_req(input longint len, input int ready_pct, input int flush_at,
                           input bit poke_start);
        longint beats_exp;
        int     beat    = 0;
        int     shifts  = 0;
        int     loads   = 0;
        int     cyc     = 0;
        int     we_wait = -1;
        bit     stalled = 0;
        bit     fin     = 0;
        bit     flushed = 0;
        logic [WB-1:0] p_keep;
        logic          p_last;

        beats_exp = (len + WB - 1) / WB;
        @(negedge clk);
        start   = 1'b1;
        out_len = len[LEN_W-1:0];
        @(negedge clk);
        start = 1'b0;

        while (!fin && cyc < 4000) begin
            cyc++;
            ready_in         = ($urandom_range(99) < ready_pct);
            output_buffer_we = 1'b0;
            start            = poke_start && valid_out && ($urandom_range(3) == 0);
            if (start) out_len = $urandom;
            if (squeeze_req) begin
                if (we_wait < 0) we_wait = $urandom_range(3);
                if (we_wait == 0) begin
                    output_buffer_we = 1'b1;
                    loads++;
                    we_wait = -1;
                end else begin
                    we_wait--;
                end
            end else if (valid_out && $urandom_range(7) == 0) begin
                output_buffer_we = 1'b1;
            end
            if (flush_at >= 0 && beat == flush_at && valid_out) begin
                flush    = 1'b1;
                ready_in = 1'b0;
            end
            #1;
            shifts += int'(output_buffer_shift_en);
            if (stalled) begin
                check("stall_valid", valid_out, 1);
                check("stall_keep", keep_out, p_keep);
                check("stall_last", last_out, p_last);
            end
            stalled = 0;
            if (valid_out) begin
                check("keep", keep_out, model_keep(len, beat));
                check("last", last_out, longint'(beat) == beats_exp - 1);
                check("shift_en", output_buffer_shift_en, ready_in);
                check("done_in_dump", done, 0);
                p_keep = keep_out;
                p_last = last_out;
                if (flush) begin
                    fin     = 1;
                    flushed = 1;
                end else if (ready_in) begin
                    beat++;
                    if (longint'(beat) == beats_exp) fin = 1;
                end else begin
                    stalled = 1;
                end
            end
            @(negedge clk);
        end

        flush            = 1'b0;
        start            = 1'b0;
        output_buffer_we = 1'b0;
        ready_in         = 1'b0;
        if (!fin) check("timeout", 1, 0);
        #1;
        if (flushed) begin
            check("flush_valid", valid_out, 0);
            check("flush_last", last_out, 0);
            check("flush_done", done, 0);
            check("flush_idle", output_buffer_available_wr, 1);
            @(negedge clk);
            check("flush_done_late", done, 0);
        end else begin
            check("done_pulse", done, 1);
            check("idle_valid", valid_out, 0);
            check("beats", beat, beats_exp);
            check("shifts", shifts, beats_exp);
            check("loads", loads, (beats_exp + RATE_WORDS - 1) / RATE_WORDS);
            @(negedge clk);
            check("done_clear", done, 0);
            check("no_squeeze_after", squeeze_req, 0);
        end
    endtask

    initial begin
        rst              = 1'b1;
        start            = 1'b0;
        out_len          = '0;
        flush            = 1'b0;
        output_buffer_we = 1'b0;
        ready_in         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {valid_out, last_out, keep_out, output_buffer_shift_en,
                              output_buffer_available_wr, squeeze_req, done}, 0);
        rst = 1'b0;
        #1;
        check("idle_avail", output_buffer_available_wr, 1);
        check("idle_squeeze", squeeze_req, 0);
        check("idle_valid0", valid_out, 0);

        run_req(32, 100, -1, 0);
        run_req(13, 100, -1, 0);
        run_req(200, 100, -1, 0);
        run_req(168, 100, -1, 0);

        // Zero-length request completes immediately without any beat.
        @(negedge clk);
        start   = 1'b1;
        out_len = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("len0_done", done, 1);
        check("len0_valid", valid_out, 0);
        check("len0_squeeze", squeeze_req, 0);
        @(negedge clk);
        check("len0_done_clear", done, 0);

        run_req(32, 100, 2, 0);
        run_req(64'h0000_0000_FFFF_FFFF, 70, 2, 0);
        run_req(64, 100, -1, 1);
        for (int i = 0; i < 12; i++) begin
            run_req(longint'($urandom_range(400, 1)), 50, -1, bit'($urandom_range(1)));
        end

        // Reset in the middle of a dump.
        @(negedge clk);
        start   = 1'b1;
        out_len = 64;
        @(negedge clk);
        start            = 1'b0;
        output_buffer_we = 1'b1;
        @(negedge clk);
        output_buffer_we = 1'b0;
        ready_in         = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("pre_rst_valid", valid_out, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {valid_out, last_out, keep_out, output_buffer_shift_en,
                                  output_buffer_available_wr, squeeze_req, done}, 0);
        @(negedge clk);
        check("held_rst_outputs", {valid_out, last_out, keep_out, output_buffer_shift_en,
                                   output_buffer_available_wr, squeeze_req, done}, 0);
        rst      = 1'b0;
        ready_in = 1'b0;
        #1;
        check("post_rst_idle", output_buffer_available_wr, 1);
        check("post_rst_valid", valid_out, 0);
        run_req(8, 100, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
